// File: rtl/cache_line_sequencer.sv
// cache_line_sequencer
// Whole-line refill / writeback engine between the tag arbiter, a single-port
// cache data RAM ({line, word} addressed, 1-cycle read latency) and a
// word-wide bus master port. Also drains every dirty line while force_sync
// is held.
//
// Optional feature macro: SEQ_BUS_TIMEOUT_EN
//   defined   - an 8-bit bus-ack watchdog aborts a stalled transfer after
//               TIMEOUT cycles and sets the sticky bus_err flag.
//   undefined - the sequencer waits indefinitely for bus_ack, bus_err = 0.
module cache_line_sequencer #(
    parameter int ENTRY_NUM  = 8,
    parameter int SEL_WIDTH  = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
    parameter int TAG_LSB    = 10,
    parameter int LINE_WORDS = 2 ** (TAG_LSB - 2),
    parameter int WIDX       = $clog2(LINE_WORDS),
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      line_miss,
    input  logic                      replace_dirty,
    input  logic [SEL_WIDTH-1:0]      entry_replace_sel,
    input  logic [31:0]               access_addr,
    input  logic                      force_sync,
    output logic                      line_refill,
    output logic [31:0]               refill_pa,
    output logic                      writeback_ok,
    output logic                      busy,
    output logic                      sync_done,
    output logic [SEL_WIDTH+WIDX-1:0] cmem_addr,
    output logic                      cmem_we,
    output logic [31:0]               cmem_wdata,
    input  logic [31:0]               cmem_rdata,
    output logic                      bus_req,
    output logic                      bus_we,
    output logic [31:0]               bus_addr,
    output logic [31:0]               bus_wdata,
    input  logic [31:0]               bus_rdata,
    input  logic                      bus_ack,
    output logic                      bus_err
);

    localparam int              TAG_W  = 32 - TAG_LSB;
    localparam logic [WIDX-1:0] LAST_W = WIDX'(LINE_WORDS - 1);
    localparam logic [WIDX-1:0] ONE_W  = WIDX'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_RD   = 3'd1,
        WB_BUS  = 3'd2,
        WB_DONE = 3'd3,
        RF_BUS  = 3'd4,
        RF_DONE = 3'd5
    } state_t;

    state_t                 state_r;
    logic [SEL_WIDTH-1:0]   vsel_r;
    logic [TAG_W-1:0]       mbase_tag_r;
    logic [WIDX-1:0]        widx_r;
    logic                   sync_mode_r;
    logic [TAG_W-1:0]       stag_r [ENTRY_NUM];

    logic                   bus_req_r;
    logic                   bus_we_r;
    logic [31:0]            bus_addr_r;
    logic                   line_refill_r;
    logic [31:0]            refill_pa_r;
    logic                   writeback_ok_r;

    logic                   timeout_s;
    logic [WIDX-1:0]        widx_inc_s;
    logic                   last_word_s;

    // Only the line-tag bits of the access address are meaningful here.
    logic unused_s;
    assign unused_s = ^access_addr[TAG_LSB-1:0];

    assign widx_inc_s  = widx_r + ONE_W;
    assign last_word_s = (widx_r == LAST_W);

`ifdef SEQ_BUS_TIMEOUT_EN
    logic [7:0] wd_cnt_r;
    logic       bus_err_r;

    assign timeout_s = bus_req_r & ~bus_ack & (wd_cnt_r == 8'(TIMEOUT - 1));

    // Watchdog: count unacknowledged request cycles, latch a sticky error on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r  <= 8'd0;
            bus_err_r <= 1'b0;
        end else if (timeout_s) begin
            wd_cnt_r  <= 8'd0;
            bus_err_r <= 1'b1;
        end else if (bus_req_r && !bus_ack) begin
            wd_cnt_r  <= wd_cnt_r + 8'd1;
        end else begin
            wd_cnt_r  <= 8'd0;
        end
    end

    assign bus_err = bus_err_r;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;
    assign timeout_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Main sequencer: state, transfer bookkeeping, shadow tags and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            vsel_r         <= {SEL_WIDTH{1'b0}};
            mbase_tag_r    <= {TAG_W{1'b0}};
            widx_r         <= {WIDX{1'b0}};
            sync_mode_r    <= 1'b0;
            bus_req_r      <= 1'b0;
            bus_we_r       <= 1'b0;
            bus_addr_r     <= 32'h0000_0000;
            line_refill_r  <= 1'b0;
            refill_pa_r    <= 32'h0000_0000;
            writeback_ok_r <= 1'b0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                stag_r[i] <= {TAG_W{1'b0}};
            end
        end else if (timeout_s) begin
            // Abort the stalled transfer silently; the arbiter sees no done pulse.
            state_r        <= IDLE;
            widx_r         <= {WIDX{1'b0}};
            sync_mode_r    <= 1'b0;
            bus_req_r      <= 1'b0;
            bus_we_r       <= 1'b0;
            bus_addr_r     <= 32'h0000_0000;
            line_refill_r  <= 1'b0;
            refill_pa_r    <= 32'h0000_0000;
            writeback_ok_r <= 1'b0;
        end else begin
            line_refill_r  <= 1'b0;
            refill_pa_r    <= 32'h0000_0000;
            writeback_ok_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (force_sync && replace_dirty) begin
                        vsel_r      <= entry_replace_sel;
                        sync_mode_r <= 1'b1;
                        widx_r      <= {WIDX{1'b0}};
                        state_r     <= WB_RD;
                    end else if (line_miss) begin
                        vsel_r      <= entry_replace_sel;
                        mbase_tag_r <= access_addr[31:TAG_LSB];
                        sync_mode_r <= 1'b0;
                        widx_r      <= {WIDX{1'b0}};
                        if (replace_dirty) begin
                            state_r <= WB_RD;
                        end else begin
                            state_r    <= RF_BUS;
                            bus_req_r  <= 1'b1;
                            bus_we_r   <= 1'b0;
                            bus_addr_r <= {access_addr[31:TAG_LSB], {TAG_LSB{1'b0}}};
                        end
                    end
                end
                WB_RD: begin
                    // cmem_addr already points at the word; its data is valid next cycle.
                    state_r    <= WB_BUS;
                    bus_req_r  <= 1'b1;
                    bus_we_r   <= 1'b1;
                    bus_addr_r <= {stag_r[vsel_r], widx_r, 2'b00};
                end
                WB_BUS: begin
                    if (bus_ack) begin
                        widx_r     <= widx_inc_s;
                        bus_req_r  <= 1'b0;
                        bus_we_r   <= 1'b0;
                        bus_addr_r <= 32'h0000_0000;
                        if (last_word_s) begin
                            state_r        <= WB_DONE;
                            writeback_ok_r <= 1'b1;
                        end else begin
                            state_r <= WB_RD;
                        end
                    end
                end
                WB_DONE: begin
                    widx_r <= {WIDX{1'b0}};
                    if (sync_mode_r) begin
                        // Back to IDLE so the arbiter can offer the next dirty line.
                        state_r <= IDLE;
                    end else begin
                        state_r    <= RF_BUS;
                        bus_req_r  <= 1'b1;
                        bus_we_r   <= 1'b0;
                        bus_addr_r <= {mbase_tag_r, {TAG_LSB{1'b0}}};
                    end
                end
                RF_BUS: begin
                    if (bus_ack) begin
                        widx_r <= widx_inc_s;
                        if (last_word_s) begin
                            state_r       <= RF_DONE;
                            bus_req_r     <= 1'b0;
                            bus_addr_r    <= 32'h0000_0000;
                            line_refill_r <= 1'b1;
                            refill_pa_r   <= {mbase_tag_r, {TAG_LSB{1'b0}}};
                        end else begin
                            bus_addr_r <= {mbase_tag_r, widx_inc_s, 2'b00};
                        end
                    end
                end
                RF_DONE: begin
                    stag_r[vsel_r] <= mbase_tag_r;
                    widx_r         <= {WIDX{1'b0}};
                    state_r        <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    widx_r      <= {WIDX{1'b0}};
                    sync_mode_r <= 1'b0;
                    bus_req_r   <= 1'b0;
                    bus_we_r    <= 1'b0;
                    bus_addr_r  <= 32'h0000_0000;
                end
            endcase
        end
    end

    // RAM-side and bus data paths are pass-throughs qualified by the current state.
    assign cmem_addr    = {vsel_r, widx_r};
    assign cmem_we      = (state_r == RF_BUS) & bus_ack;
    assign cmem_wdata   = (state_r == RF_BUS) ? bus_rdata : 32'h0000_0000;
    assign bus_wdata    = (state_r == WB_BUS) ? cmem_rdata : 32'h0000_0000;

    assign bus_req      = bus_req_r;
    assign bus_we       = bus_we_r;
    assign bus_addr     = bus_addr_r;
    assign line_refill  = line_refill_r;
    assign refill_pa    = refill_pa_r;
    assign writeback_ok = writeback_ok_r;
    assign busy         = (state_r != IDLE);
    assign sync_done    = force_sync & ~replace_dirty & (state_r == IDLE);

endmodule

// File: tb/tb_cache_line_sequencer.sv
// Directed bench for cache_line_sequencer: 4 lines of 4 words (TAG_LSB = 4),
// a behavioural cache RAM and a bus slave with zero-wait, wait-state and
// no-ack modes. Expected values are derived from the stimulus addresses.
module tb_cache_line_sequencer;

    localparam int ENTRY_NUM = 4;
    localparam int SEL_WIDTH = 2;
    localparam int TAG_LSB   = 4;
    localparam int WIDX      = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      line_miss = 1'b0;
    logic                      replace_dirty = 1'b0;
    logic [SEL_WIDTH-1:0]      entry_replace_sel = 2'd0;
    logic [31:0]               access_addr = 32'h0;
    logic                      force_sync = 1'b0;
    logic                      line_refill;
    logic [31:0]               refill_pa;
    logic                      writeback_ok;
    logic                      busy;
    logic                      sync_done;
    logic [SEL_WIDTH+WIDX-1:0] cmem_addr;
    logic                      cmem_we;
    logic [31:0]               cmem_wdata;
    logic [31:0]               cmem_rdata;
    logic                      bus_req;
    logic                      bus_we;
    logic [31:0]               bus_addr;
    logic [31:0]               bus_wdata;
    logic [31:0]               bus_rdata;
    logic                      bus_ack;
    logic                      bus_err;

    cache_line_sequencer #(
        .ENTRY_NUM(ENTRY_NUM),
        .TAG_LSB  (TAG_LSB),
        .TIMEOUT  (16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .line_miss(line_miss), .replace_dirty(replace_dirty),
        .entry_replace_sel(entry_replace_sel), .access_addr(access_addr),
        .force_sync(force_sync), .line_refill(line_refill), .refill_pa(refill_pa),
        .writeback_ok(writeback_ok), .busy(busy), .sync_done(sync_done),
        .cmem_addr(cmem_addr), .cmem_we(cmem_we), .cmem_wdata(cmem_wdata),
        .cmem_rdata(cmem_rdata), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Bus slave read data pattern, a pure function of the word address.
    function automatic logic [31:0] bus_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    // Cache data RAM model: synchronous write, 1-cycle registered read.
    logic [31:0] cram [16];
    logic [31:0] cram_q = 32'h0;
    initial for (int i = 0; i < 16; i++) cram[i] = 32'h0;
    always @(posedge clk) begin
        if (cmem_we) cram[cmem_addr] <= cmem_wdata;
        cram_q <= cram[cmem_addr];
    end
    assign cmem_rdata = cram_q;

    // Bus slave: zero-wait, ack every 3rd request cycle, or never.
    logic       wait_mode = 1'b0;
    logic       no_ack    = 1'b0;
    logic [1:0] wcnt      = 2'd0;
    assign bus_ack   = bus_req & ~no_ack & (~wait_mode | (wcnt == 2'd2));
    assign bus_rdata = bus_word(bus_addr);
    always @(posedge clk) begin
        if (!bus_req || bus_ack) wcnt <= 2'd0;
        else                     wcnt <= wcnt + 2'd1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Per-transaction event log, cycles counted from the cycle the request is sampled in.
    int          rel, refill_rel, n_refill, sync_rel, req_cycles;
    logic [31:0] refill_pa_seen;
    logic [31:0] rd_addr_q [$];
    int          rd_rel_q  [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          wr_rel_q  [$];
    int          cw_addr_q [$];
    int          wb_rel_q  [$];
    logic        prev_wait;
    logic [31:0] prev_addr, prev_wdata;

    task automatic clear_log();
        rel = 0; refill_rel = -1; n_refill = 0; sync_rel = -1; req_cycles = 0;
        refill_pa_seen = 32'h0; prev_wait = 1'b0;
        rd_addr_q.delete(); rd_rel_q.delete(); wr_addr_q.delete();
        wr_data_q.delete(); wr_rel_q.delete(); cw_addr_q.delete(); wb_rel_q.delete();
    endtask

    task automatic step();
        @(negedge clk);
        rel++;
        if (prev_wait) begin
            check("hold_req", {31'd0, bus_req}, 32'd1);
            check("hold_addr", bus_addr, prev_addr);
            if (bus_we) check("hold_wdata", bus_wdata, prev_wdata);
        end
        prev_wait  = bus_req && !bus_ack;
        prev_addr  = bus_addr;
        prev_wdata = bus_wdata;
        if (bus_req) req_cycles++;
        if (bus_req && bus_ack) begin
            if (bus_we) begin
                wr_addr_q.push_back(bus_addr); wr_data_q.push_back(bus_wdata); wr_rel_q.push_back(rel);
            end else begin
                rd_addr_q.push_back(bus_addr); rd_rel_q.push_back(rel);
            end
        end
        if (cmem_we) cw_addr_q.push_back(int'(cmem_addr));
        if (line_refill) begin
            n_refill++; refill_rel = rel; refill_pa_seen = refill_pa;
        end
        if (writeback_ok) wb_rel_q.push_back(rel);
        if (sync_done && sync_rel < 0) sync_rel = rel;
    endtask

    task automatic run_to_idle(input int max_cycles);
        int k = 0;
        while (busy && k < max_cycles) begin
            step();
            k++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [1:0] sel, input logic dirty);
        clear_log();
        line_miss = 1'b1; access_addr = addr; entry_replace_sel = sel; replace_dirty = dirty;
        step();
        line_miss = 1'b0; replace_dirty = 1'b0;
        run_to_idle(200);
    endtask

    task automatic check_reads(input string tag, input logic [31:0] base, input int first_rel, input int pitch);
        check({tag, "_nrd"}, rd_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_rd_addr"}, (i < rd_addr_q.size()) ? rd_addr_q[i] : 32'hFFFF_FFFF, base + 32'(4 * i));
            check({tag, "_rd_cyc"}, (i < rd_rel_q.size()) ? rd_rel_q[i] : -1, first_rel + pitch * i);
        end
    endtask

    task automatic check_line(input string tag, input int line, input logic [31:0] base);
        for (int i = 0; i < 4; i++) check({tag, "_cram"}, cram[line * 4 + i], bus_word(base + 32'(4 * i)));
    endtask

    task automatic check_writes(input string tag, input int from, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_wr_addr"}, (from + i < wr_addr_q.size()) ? wr_addr_q[from + i] : 32'hFFFF_FFFF, base + 32'(4 * i));
            check({tag, "_wr_data"}, (from + i < wr_data_q.size()) ? wr_data_q[from + i] : 32'hFFFF_FFFF, bus_word(base + 32'(4 * i)));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
        check({tag, "_bus_addr"}, bus_addr, 32'd0);
        check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        check({tag, "_cmem_we"}, {31'd0, cmem_we}, 32'd0);
        check({tag, "_cmem_addr"}, {28'd0, cmem_addr}, 32'd0);
        check({tag, "_cmem_wdata"}, cmem_wdata, 32'd0);
        check({tag, "_refill"}, {31'd0, line_refill}, 32'd0);
        check({tag, "_refill_pa"}, refill_pa, 32'd0);
        check({tag, "_wb_ok"}, {31'd0, writeback_ok}, 32'd0);
        check({tag, "_sync_done"}, {31'd0, sync_done}, 32'd0);
        check({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] dirty;
        int k;

        // Power-on reset
        #3;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean miss, zero-wait slave
        do_miss(32'h0000_1404, 2'd2, 1'b0);
        check_reads("clean", 32'h0000_1400, 1, 1);
        check("clean_ncw", cw_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) check("clean_cw_addr", (i < cw_addr_q.size()) ? cw_addr_q[i] : -1, 8 + i);
        check("clean_refill_cyc", refill_rel, 5);
        check("clean_refill_pa", refill_pa_seen, 32'h0000_1400);
        check("clean_nrefill", n_refill, 1);
        check("clean_idle_cyc", rel, 6);
        check_line("clean", 2, 32'h0000_1400);

        // Dirty miss: line 1 first gets tag 0x2000, then is evicted by 0x3000
        do_miss(32'h0000_2000, 2'd1, 1'b0);
        do_miss(32'h0000_3008, 2'd1, 1'b1);
        check("dirty_nwr", wr_addr_q.size(), 4);
        check_writes("dirty", 0, 32'h0000_2000);
        for (int i = 0; i < 4; i++) check("dirty_wr_cyc", (i < wr_rel_q.size()) ? wr_rel_q[i] : -1, 2 + 2 * i);
        check("dirty_nwb", wb_rel_q.size(), 1);
        check("dirty_wb_cyc", (wb_rel_q.size() > 0) ? wb_rel_q[0] : -1, 9);
        check_reads("dirty", 32'h0000_3000, 10, 1);
        check("dirty_refill_cyc", refill_rel, 14);
        check("dirty_refill_pa", refill_pa_seen, 32'h0000_3000);
        check_line("dirty", 1, 32'h0000_3000);

        // Wait-stated slave: ack on every 3rd request cycle
        wait_mode = 1'b1;
        do_miss(32'h0000_7004, 2'd3, 1'b0);
        wait_mode = 1'b0;
        check_reads("wait", 32'h0000_7000, 3, 3);
        check("wait_ncw", cw_addr_q.size(), 4);
        check("wait_refill_cyc", refill_rel, 13);
        check_line("wait", 3, 32'h0000_7000);

        // Force sync: lines 0 and 3 dirty, a miss to 0x6000 pending meanwhile
        do_miss(32'h0000_4000, 2'd0, 1'b0);
        clear_log();
        dirty = 4'b1001;
        force_sync = 1'b1; line_miss = 1'b1; access_addr = 32'h0000_6000;
        entry_replace_sel = 2'd0; replace_dirty = 1'b1;
        k = 0;
        while (!(n_refill == 1 && !busy) && k < 200) begin
            step();
            k++;
            if (writeback_ok) dirty[entry_replace_sel] = 1'b0;
            if (sync_rel >= 0 && rel > sync_rel) begin
                force_sync = 1'b0; line_miss = 1'b0;
            end
            replace_dirty = |dirty;
            entry_replace_sel = dirty[0] ? 2'd0 : (dirty[1] ? 2'd1 : (dirty[3] ? 2'd3 : 2'd2));
        end
        force_sync = 1'b0; line_miss = 1'b0;
        check("sync_finished", {31'd0, busy}, 32'd0);
        check("sync_nwb", wb_rel_q.size(), 2);
        check("sync_wb0_cyc", (wb_rel_q.size() > 0) ? wb_rel_q[0] : -1, 9);
        check("sync_wb1_cyc", (wb_rel_q.size() > 1) ? wb_rel_q[1] : -1, 19);
        check("sync_nwr", wr_addr_q.size(), 8);
        check_writes("sync_l0", 0, 32'h0000_4000);
        check_writes("sync_l3", 4, 32'h0000_7000);
        check("sync_done_cyc", sync_rel, 20);
        check_reads("sync_miss", 32'h0000_6000, 21, 1);
        check("sync_refill_pa", refill_pa_seen, 32'h0000_6000);

        // Asynchronous reset in the middle of a refill burst
        clear_log();
        line_miss = 1'b1; access_addr = 32'h0000_8000; entry_replace_sel = 2'd0; replace_dirty = 1'b0;
        step();
        line_miss = 1'b0;
        step();
        check("midrst_pre_req", {31'd0, bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 8; i++) step();
        check("midrst_no_refill", n_refill, 0);
        check("midrst_no_wb", wb_rel_q.size(), 0);
        check("midrst_idle", {31'd0, busy}, 32'd0);

        // Shadow tags were cleared by reset: a dirty eviction of line 0 writes from 0x0
        do_miss(32'h0000_9000, 2'd0, 1'b1);
        check("stag_rst_nwr", wr_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) check("stag_rst_wr_addr", (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hFFFF_FFFF, 32'(4 * i));
        check("stag_rst_refill_pa", refill_pa_seen, 32'h0000_9000);

`ifdef SEQ_BUS_TIMEOUT_EN
        // Bus watchdog: a slave that never acks
        no_ack = 1'b1;
        do_miss(32'h0000_A000, 2'd2, 1'b0);
        no_ack = 1'b0;
        check("tmo_req_cycles", req_cycles, 16);
        check("tmo_idle_cyc", rel, 17);
        check("tmo_no_refill", n_refill, 0);
        check("tmo_bus_err", {31'd0, bus_err}, 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("tmo_bus_err_sticky", {31'd0, bus_err}, 32'd1);
        check("tmo_bus_req_low", {31'd0, bus_req}, 32'd0);
`else
        check("no_watchdog_bus_err", {31'd0, bus_err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_sequencer.md
# cache_line_sequencer

Refill/writeback sequencer for the BIU cache tag arbiter. Turns the arbiter's `line_miss`, `replace_dirty` and `entry_replace_sel` outputs into whole-line transfers between a single-port cache data RAM and a word-wide bus master port. Pulses `line_refill` and `writeback_ok` back to the arbiter. Also drains all dirty lines on a `force_sync` request. Sits between the tag arbiter, the cache data memory and the BIU bus.

## Interface
Parameters:
- `ENTRY_NUM`, 8: number of cache lines; must match the tag arbiter.
- `SEL_WIDTH`, `$clog2(ENTRY_NUM)` (1 if `ENTRY_NUM`=1): line select width.
- `TAG_LSB`, 10: address bit where the tag starts; line = 2^TAG_LSB bytes.
- `LINE_WORDS`, 2^(TAG_LSB-2): 32-bit words per line.
- `WIDX`, `$clog2(LINE_WORDS)`: word index width.
- `TIMEOUT`, 255: bus-ack watchdog limit in cycles; used only with `SEQ_BUS_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `line_miss` in 1: miss from the tag arbiter.
- `replace_dirty` in 1: victim (or any line, under sync) is dirty.
- `entry_replace_sel` in SEL_WIDTH: victim / dirty line index.
- `access_addr` in 32: core access address.
- `force_sync` in 1: level request to write back all dirty lines.
- `line_refill` out 1: one-cycle refill-done pulse to the arbiter.
- `refill_pa` out 32: line base of the refilled line, valid while `line_refill`=1.
- `writeback_ok` out 1: one-cycle writeback-done pulse to the arbiter.
- `busy` out 1: core stall; high whenever state ≠ IDLE.
- `sync_done` out 1: high while `force_sync`=1, `replace_dirty`=0 and state is IDLE.
- `cmem_addr` out SEL_WIDTH+WIDX: {line, word} address into the cache RAM.
- `cmem_we` out 1: cache RAM write strobe.
- `cmem_wdata` out 32: cache RAM write data.
- `cmem_rdata` in 32: cache RAM read data, 1-cycle read latency.
- `bus_req` out 1: bus request, held until `bus_ack`.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address, bits [1:0]=0.
- `bus_wdata` out 32: bus write data.
- `bus_rdata` in 32: bus read data, valid with `bus_ack`.
- `bus_ack` in 1: one word transferred this cycle.
- `bus_err` out 1: sticky timeout flag; tied 0 unless the macro is defined.

## Operation
States: IDLE, WB_RD, WB_BUS, WB_DONE, RF_BUS, RF_DONE.

Internal storage:
- Shadow tag table `stag[ENTRY_NUM]`, each `[31:TAG_LSB]`, written at refill.
- Latched victim `vsel`, miss line base `mbase`, word counter `widx`, flag `sync_mode`.

Transitions:
- **IDLE**, evaluated in priority order:
  1. `force_sync & replace_dirty`: latch `vsel`, set `sync_mode`=1, go to WB_RD.
  2. `line_miss`: latch `vsel`, latch `mbase = {access_addr[31:TAG_LSB], 0}`, clear `sync_mode`. Go to WB_RD if `replace_dirty`, else RF_BUS.
- **WB_RD**: drive `cmem_addr = {vsel, widx}`, then go to WB_BUS.
- **WB_BUS**:
  - `bus_req`=1, `bus_we`=1.
  - `bus_addr = {stag[vsel], widx, 2'b00}`.
  - `bus_wdata = cmem_rdata`; `cmem_addr` is held, so the read data stays stable.
  - On `bus_ack`: `widx`++. If it was the last word, go to WB_DONE; otherwise go to WB_RD.
- **WB_DONE**: `writeback_ok`=1 for one cycle, `widx`=0. If `sync_mode`, go to IDLE (the next dirty line is re-evaluated there); otherwise go to RF_BUS.
- **RF_BUS**:
  - `bus_req`=1, `bus_we`=0, `bus_addr = mbase + 4·widx`.
  - `cmem_we = bus_ack`, `cmem_wdata = bus_rdata`, `cmem_addr = {vsel, widx}` (combinational).
  - On `bus_ack`: `widx`++. After the last word, go to RF_DONE.
- **RF_DONE**: `line_refill`=1, `refill_pa = mbase`, `stag[vsel] <= mbase[31:TAG_LSB]`, `widx`=0, then go to IDLE.

Rules:
- `widx` wraps to 0 after word LINE_WORDS-1.
- Only state IDLE samples arbiter inputs. Inputs are ignored at all other times.
- `mbase` and `vsel` are stable for the whole transaction.

## Timing
- Reset (asynchronous, takes effect immediately) drives all of the following to 0: every output, `stag`, `widx`, `vsel`, `mbase`, `bus_err`; state returns to IDLE. A reset in mid-burst drops `bus_req` immediately, and no done pulse follows.
- Clean miss, zero-wait slave, with the miss sampled in cycle 0:
  - Cycles 1..N (N = LINE_WORDS): RF_BUS, one word per cycle.
  - Cycle N+1: `line_refill`.
  - Cycle N+2: `busy`=0, and the arbiter hits.
- Dirty miss, zero-wait slave:
  - Writeback takes 2 cycles per word, cycles 1..2N.
  - Cycle 2N+1: `writeback_ok`.
  - Cycles 2N+2..3N+1: refill.
  - Cycle 3N+2: `line_refill`.
- A wait-stated `bus_ack` stretches WB_BUS or RF_BUS; `bus_req`, `bus_addr` and `bus_wdata` stay stable until the ack.
- `force_sync` and `line_miss` in the same IDLE cycle: sync wins while any line is dirty; the miss is serviced after `sync_done`.
- Every done pulse is exactly 1 cycle, followed by at least 1 IDLE cycle (or refill) before the next arbiter sample.

## Configuration
`SEQ_BUS_TIMEOUT_EN`:
- **Defined**: an 8-bit watchdog counts cycles with `bus_req`=1 and no `bus_ack`, and clears on ack. When it reaches `TIMEOUT`:
  - `bus_err` is set and stays set until reset.
  - `bus_req` drops, state returns to IDLE, and no done pulse is issued.
- **Undefined**: no counter; the block waits indefinitely for `bus_ack`; `bus_err` = 0.

## Test plan
Bench configuration: `LINE_WORDS`=4, `ENTRY_NUM`=4.
- **Reset**: assert `rst_n`=0 mid-cycle → all outputs 0 immediately; state IDLE.
- **Clean miss**: miss at `access_addr`=0x0000_1404, sel=2, zero-wait ack → bus reads 0x1400, 0x1404, 0x1408, 0x140C in cycles 1-4; `cmem_we` at addresses {2,0..3}; cycle 5 `line_refill`=1 with `refill_pa`=0x1400; cycle 6 `busy`=0.
- **Dirty miss**: line 1 holds tag 0x2000, next miss at 0x3000 with sel=1 and dirty → 4 writes to 0x2000..0x200C carrying the `cmem` words; `writeback_ok` in cycle 9; reads from 0x3000; `line_refill` in cycle 14.
- **Wait states**: ack every 3rd cycle during refill → address and request held stable; exactly 4 `cmem_we` pulses.
- **Force sync**: lines 0 and 3 dirty, `force_sync` held → two writebacks, each with its own `writeback_ok`; then `sync_done`=1; a miss arriving meanwhile is serviced only afterwards.
- **Timeout** (macro defined, `TIMEOUT`=16): no ack → `bus_req` drops after 16 cycles; `bus_err`=1 and stays 1; no `line_refill`.
